// File: rtl/sr_ctrl_pkg.sv
// Shared types and constants for the serial shift-register controller.
package sr_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/sr_shift_ctrl_if.sv
// Command and shift-register control bundle for sr_shift_ctrl.
// The slave modport is the controller side; master is the requester/register side.
interface sr_shift_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             req0_valid;
    logic             req0_ready;
    logic             req0_dir;
    logic [WIDTH-1:0] req0_data;
    logic [CNT_W-1:0] req0_len;
    logic             req1_valid;
    logic             req1_ready;
    logic             req1_dir;
    logic [WIDTH-1:0] req1_data;
    logic [CNT_W-1:0] req1_len;
    logic             sl;
    logic             sr;
    logic             din;
    logic             busy;
    logic             done;
    logic             grant_id;

    modport slave (
        input  req0_valid, req0_dir, req0_data, req0_len,
        input  req1_valid, req1_dir, req1_data, req1_len,
        output req0_ready, req1_ready,
        output sl, sr, din, busy, done, grant_id
    );

    modport master (
        output req0_valid, req0_dir, req0_data, req0_len,
        output req1_valid, req1_dir, req1_data, req1_len,
        input  req0_ready, req1_ready,
        input  sl, sr, din, busy, done, grant_id
    );
endinterface

// File: rtl/sr_shift_ctrl_arb.sv
// rr_arb2: two-requester round-robin arbiter, combinational grant,
// priority moves to the other requester whenever a grant is accepted.
module rr_arb2 (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic valid0_i,
    input  logic valid1_i,
    output logic gnt0_o,
    output logic gnt1_o,
    output logic gnt_id_o,
    output logic accept_o
);
    logic prio_q;
    logic prio_d;

    // Grant selection: prio_q = 1 favours requester 1 on a tie.
    always_comb begin
        gnt0_o = 1'b0;
        gnt1_o = 1'b0;
        if (!en_i) begin
            gnt0_o = 1'b0;
            gnt1_o = 1'b0;
        end else if (valid0_i && valid1_i) begin
            gnt0_o = ~prio_q;
            gnt1_o = prio_q;
        end else if (valid0_i) begin
            gnt0_o = 1'b1;
        end else if (valid1_i) begin
            gnt1_o = 1'b1;
        end else begin
            gnt0_o = 1'b0;
            gnt1_o = 1'b0;
        end
    end

    assign accept_o = gnt0_o | gnt1_o;
    assign gnt_id_o = gnt1_o;

    // Priority next-state.
    always_comb begin
        prio_d = prio_q;
        if (accept_o) begin
            prio_d = ~gnt_id_o;
        end else begin
            prio_d = prio_q;
        end
    end

    // Priority register.
    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end
endmodule

// File: rtl/sr_shift_ctrl.sv
// Sequencer/arbiter driving sl/sr/din of a serial shift register.
// Optional `hold` input is compiled in with SRCTRL_HOLD_EN.
module sr_shift_ctrl
    import sr_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic               clk,
    input  logic               reset,
`ifdef SRCTRL_HOLD_EN
    input  logic               hold,
`endif
    sr_shift_ctrl_if.slave     bus
);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] buf_q, buf_d;
    logic             dir_q, dir_d;
    logic             gid_q, gid_d;

    logic             hold_s;
    logic             gnt0_s, gnt1_s, gnt_id_s, accept_s;
    logic             sel_dir_s;
    logic [WIDTH-1:0] sel_data_s;
    logic [CNT_W-1:0] sel_len_s;
    logic [WIDTH-1:0] load_s;

`ifdef SRCTRL_HOLD_EN
    assign hold_s = hold;
`else
    assign hold_s = 1'b0;
`endif

    function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = v[WIDTH-1-i];
        end
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] eff_len(input logic [CNT_W-1:0] len);
        logic [CNT_W-1:0] r;
        if ((len == '0) || (32'(len) > 32'(WIDTH))) begin
            r = CNT_W'(WIDTH);
        end else begin
            r = len;
        end
        return r;
    endfunction

    rr_arb2 u_arb (
        .clk      (clk),
        .reset    (reset),
        .en_i     ((state_q == IDLE) && !hold_s),
        .valid0_i (bus.req0_valid),
        .valid1_i (bus.req1_valid),
        .gnt0_o   (gnt0_s),
        .gnt1_o   (gnt1_s),
        .gnt_id_o (gnt_id_s),
        .accept_o (accept_s)
    );

    assign sel_dir_s  = gnt_id_s ? bus.req1_dir  : bus.req0_dir;
    assign sel_data_s = gnt_id_s ? bus.req1_data : bus.req0_data;
    assign sel_len_s  = eff_len(gnt_id_s ? bus.req1_len : bus.req0_len);

    // The buffer always emits bit 0; a left load is reversed and aligned so
    // data[n-1] comes out first.
    assign load_s = (sel_dir_s == DIR_RIGHT) ? sel_data_s
                  : (bit_rev(sel_data_s) >> (CNT_W'(WIDTH) - sel_len_s));

    // FSM next-state and datapath update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        dir_d   = dir_q;
        gid_d   = gid_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = SHIFT;
                    dir_d   = sel_dir_s;
                    buf_d   = load_s;
                    cnt_d   = sel_len_s;
                    gid_d   = gnt_id_s;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (hold_s) begin
                    state_d = SHIFT;
                end else begin
                    buf_d = buf_q >> 1;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset leaves the shift register untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            buf_q   <= '0;
            dir_q   <= DIR_LEFT;
            gid_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            dir_q   <= dir_d;
            gid_q   <= gid_d;
        end
    end

    assign bus.req0_ready = gnt0_s;
    assign bus.req1_ready = gnt1_s;
    assign bus.sl         = (state_q == SHIFT) && (dir_q == DIR_LEFT)  && !hold_s;
    assign bus.sr         = (state_q == SHIFT) && (dir_q == DIR_RIGHT) && !hold_s;
    assign bus.din        = (state_q == SHIFT) ? buf_q[0] : 1'b0;
    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = (state_q == DONE);
    assign bus.grant_id   = gid_q;
endmodule

// File: tb/tb_sr_shift_ctrl.sv
// Self-checking bench for sr_shift_ctrl: transaction-level reference model
// compared every cycle, plus directed literal checks.
module tb_sr_shift_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    bit   chk_en = 1'b0;

    always #5 clk = ~clk;

    sr_shift_ctrl_if #(.WIDTH(8), .CNT_W(4)) bus ();

    sr_shift_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Shift register fixture driven by the controller outputs
    logic [7:0] fix_q = 8'h00;
    always @(posedge clk) begin
        if (bus.sl)      fix_q <= {fix_q[6:0], bus.din};
        else if (bus.sr) fix_q <= {bus.din, fix_q[7:1]};
    end

    bit bits[$];
    always @(negedge clk) if (bus.sl || bus.sr) bits.push_back(bus.din);

    // Reference model: k = cycles since handshake (0 = idle)
    int         m_k = 0, m_n = 8, m_w;
    logic       m_dir = 1'b0, m_gid = 1'b0, m_prio = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic       e_r0, e_r1, e_sl, e_sr, e_din, e_busy, e_done;

    always @(negedge clk) begin
        e_r0 = 1'b0; e_r1 = 1'b0; e_sl = 1'b0; e_sr = 1'b0;
        e_din = 1'b0; e_busy = 1'b0; e_done = 1'b0;
        if (m_k == 0) begin
            if (bus.req0_valid && bus.req1_valid) begin
                e_r0 = !m_prio;
                e_r1 = m_prio;
            end else begin
                e_r0 = bus.req0_valid;
                e_r1 = bus.req1_valid;
            end
        end else if (m_k <= m_n) begin
            e_busy = 1'b1;
            e_sl   = !m_dir;
            e_sr   = m_dir;
            e_din  = m_dir ? m_data[m_k-1] : m_data[m_n-m_k];
        end else begin
            e_busy = 1'b1;
            e_done = 1'b1;
        end
        if (chk_en) begin
            chk("m_ready0", bus.req0_ready, e_r0);
            chk("m_ready1", bus.req1_ready, e_r1);
            chk("m_ready_excl", bus.req0_ready & bus.req1_ready, 1'b0);
            chk("m_sl", bus.sl, e_sl);
            chk("m_sr", bus.sr, e_sr);
            chk("m_din", bus.din, e_din);
            chk("m_busy", bus.busy, e_busy);
            chk("m_done", bus.done, e_done);
            chk("m_grant_id", bus.grant_id, m_gid);
        end
        if (reset) begin
            m_k = 0; m_prio = 1'b0; m_gid = 1'b0;
        end else if (m_k == 0) begin
            if (e_r0 || e_r1) begin
                m_w    = e_r1 ? 1 : 0;
                m_dir  = e_r1 ? bus.req1_dir  : bus.req0_dir;
                m_data = e_r1 ? bus.req1_data : bus.req0_data;
                m_n    = int'(e_r1 ? bus.req1_len : bus.req0_len);
                if (m_n == 0 || m_n > 8) m_n = 8;
                m_gid  = e_r1;
                m_prio = !e_r1;
                m_k    = 1;
            end
        end else if (m_k == m_n + 1) begin
            m_k = 0;
        end else begin
            m_k++;
        end
    end

    task automatic drive(input int r, input logic v, input logic dir, input logic [7:0] d, input logic [3:0] len);
        if (r == 0) begin
            bus.req0_valid = v; bus.req0_dir = dir; bus.req0_data = d; bus.req0_len = len;
        end else begin
            bus.req1_valid = v; bus.req1_dir = dir; bus.req1_data = d; bus.req1_len = len;
        end
    endtask

    task automatic wait_ready(output int hs_cyc);
        int g = 0;
        while (1) begin
            @(negedge clk);
            if (bus.req0_ready || bus.req1_ready) break;
            g++;
            if (g > 20) begin chk("ready_timeout", 32'd0, 32'd1); break; end
        end
        hs_cyc = cyc;
    endtask

    task automatic wait_done(output int d_cyc);
        int g = 0;
        while (1) begin
            @(negedge clk);
            if (bus.done) break;
            g++;
            if (g > 40) begin chk("done_timeout", 32'd0, 32'd1); break; end
        end
        d_cyc = cyc;
    endtask

    function automatic logic [7:0] bits_vec();
        logic [7:0] v = 8'h00;
        foreach (bits[i]) v = {v[6:0], bits[i]};
        return v;
    endfunction

    task automatic send(input int r, input logic dir, input logic [7:0] d, input logic [3:0] len, output int lat);
        int hs, dn;
        @(posedge clk); #1;
        bits.delete();
        drive(r, 1'b1, dir, d, len);
        wait_ready(hs);
        chk("send_ready_owner", (r == 0) ? bus.req0_ready : bus.req1_ready, 1'b1);
        @(posedge clk); #1;
        drive(r, 1'b0, dir, d, len);
        wait_done(dn);
        lat = dn - hs;
    endtask

    initial begin
        int lat, hs, dn, ndone;
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 8'h00, 4'd0);
        drive(1, 1'b0, 1'b0, 8'h00, 4'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_strobes", {bus.sl, bus.sr, bus.din}, 3'b000);
        chk("rst_grant_id", bus.grant_id, 1'b0);
        chk("rst_readies", {bus.req0_ready, bus.req1_ready}, 2'b00);

        // Left load A5
        send(0, 1'b0, 8'hA5, 4'd8, lat);
        chk("left_lat", lat, 9);
        chk("left_nbits", bits.size(), 8);
        chk("left_din_seq", bits_vec(), 8'hA5);
        chk("left_q", fix_q, 8'hA5);

        // Right load 3C, len 0
        send(1, 1'b1, 8'h3C, 4'd0, lat);
        chk("right_lat", lat, 9);
        chk("right_din_seq", bits_vec(), 8'h3C);
        chk("right_q", fix_q, 8'h3C);
        chk("right_grant_id", bus.grant_id, 1'b1);

        // Arbitration: both valid across two transactions
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 8'h81, 4'd8);
        drive(1, 1'b1, 1'b1, 8'h42, 4'd4);
        wait_ready(hs);
        chk("arb_first_r0", bus.req0_ready, 1'b1);
        wait_done(dn);
        wait_ready(hs);
        chk("arb_second_r1", bus.req1_ready, 1'b1);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 8'h81, 4'd8);
        drive(1, 1'b0, 1'b1, 8'h42, 4'd4);
        wait_done(dn);
        chk("arb_second_lat", dn - hs, 5);
        chk("arb_grant_id", bus.grant_id, 1'b1);

        // Short and clamped lengths
        send(0, 1'b0, 8'h05, 4'd3, lat);
        chk("short_lat", lat, 4);
        chk("short_nbits", bits.size(), 3);
        chk("short_din_seq", bits_vec(), 8'h05);
        chk("short_q", fix_q[2:0], 3'b101);
        send(1, 1'b0, 8'h5A, 4'd12, lat);
        chk("clamp_lat", lat, 9);
        chk("clamp_nbits", bits.size(), 8);
        chk("clamp_q", fix_q, 8'h5A);

        // Reset in the 4th SHIFT cycle
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 8'hFF, 4'd8);
        wait_ready(hs);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 8'hFF, 4'd8);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("abort_sl_before", bus.sl, 1'b1);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("abort_sl", bus.sl, 1'b0);
        chk("abort_busy", bus.busy, 1'b0);
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b1, 8'hC3, 4'd2);
        drive(1, 1'b1, 1'b0, 8'h3C, 4'd2);
        @(negedge clk);
        chk("post_rst_tie", {bus.req0_ready, bus.req1_ready}, 2'b10);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b1, 8'hC3, 4'd2);
        drive(1, 1'b0, 1'b0, 8'h3C, 4'd2);
        wait_done(dn);
        chk("post_rst_grant_id", bus.grant_id, 1'b0);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sr_shift_ctrl.md
# sr_shift_ctrl

Sequencer and two-way arbiter for the 8-bit left/right serial shift register. It accepts byte-load commands from two requesters, grants one at a time round-robin, and drives the register's `sl`, `sr` and `din` inputs for exactly the commanded number of shift cycles. It signals completion with a one-cycle `done` pulse. It sits between the command sources and the shift register, and is the only driver of that register's shift controls.

## Interface
- `WIDTH`, default 8: width of the shift register and of the command data.
- `CNT_W`, default 4: width of the length field; must equal $clog2(WIDTH+1).
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req0_valid` / `req1_valid`  in  1  command request.
- `req0_ready` / `req1_ready`  out  1  command accepted this cycle.
- `req0_dir` / `req1_dir`  in  1  0 = shift left, 1 = shift right.
- `req0_data` / `req1_data`  in  WIDTH  word to shift in.
- `req0_len` / `req1_len`  in  CNT_W  number of shifts; 0 means WIDTH.
- `sl`  out  1  shift-left strobe to the register.
- `sr`  out  1  shift-right strobe to the register.
- `din`  out  1  serial bit to the register.
- `busy`  out  1  a transaction is in progress.
- `done`  out  1  one-cycle pulse marking the end of a transaction.
- `grant_id`  out  1  requester that owns the current or most recent transaction.
- `hold`  in  1  pause shifting; present only with SRCTRL_HOLD_EN.

## Operation
- FSM states are IDLE, SHIFT and DONE.
- **IDLE:**
  - The arbiter picks one asserted valid.
  - On a tie, the requester not granted last wins.
  - `reqN_ready` is combinational and is high only for the winner, only in IDLE.
  - On valid&ready the block captures dir, data and the effective length, updates `grant_id`, flips round-robin priority to the other requester, and moves to SHIFT.
- **Effective length:** 0 means WIDTH; values above WIDTH are clamped to WIDTH.
- **SHIFT:**
  - Each active cycle asserts exactly one of `sl` (dir 0) or `sr` (dir 1).
  - One bit is consumed per active cycle; after the last bit the FSM moves to DONE.
- **Bit order, left:** data[n-1] down to data[0]. Result: Q[n-1:0] = data[n-1:0]. For n = WIDTH, Q = data.
- **Bit order, right:** data[0] up to data[n-1]. Result: Q[WIDTH-1:WIDTH-n] = data[n-1:0]. For n = WIDTH, Q = data.
- **DONE:** `done` = 1 for one cycle, then return to IDLE. No command is accepted in DONE.
- `sl`, `sr` and `din` are decoded from registered state only, gated by `hold` when it is compiled in.
- Outside SHIFT: `sl` = `sr` = 0 and `din` = 0.
- Requesters must hold valid, dir, data and len stable until ready. Dropping valid before ready is legal and no grant occurs.
- **Reset values:** state IDLE; `sl`, `sr`, `din`, `busy`, `done` and `grant_id` all 0; both readies 0; priority favours req0.
- **Reset mid-transaction:** abort. Strobes are low from the next cycle, no `done` is produced, and the shift register's own contents are not touched.

## Timing
- Handshake in cycle T.
- Strobe high in cycles T+1 through T+n; the register samples at the end of each.
- `done` high in cycle T+n+1.
- `busy` high in cycles T+1 through T+n+1.
- Earliest next handshake is T+n+2.
- Arbitration has zero latency: ready follows valid combinationally within the same IDLE cycle.

## Configuration
- **SRCTRL_HOLD_EN defined:**
  - `hold` port exists.
  - In SHIFT, `hold` = 1 forces `sl` = `sr` = 0 and freezes the bit counter and data buffer; `din` keeps its value.
  - In IDLE, `hold` = 1 forces both readies to 0.
  - `done` is delayed by the number of held cycles.
- **SRCTRL_HOLD_EN undefined:** no `hold` port; shifting runs uninterrupted for n cycles.

## Structure
- Package `sr_ctrl_pkg` holds:
  - the state enum (IDLE, SHIFT, DONE);
  - the constants DIR_LEFT = 0 and DIR_RIGHT = 1.
- Sub-module `rr_arb2` is a two-requester round-robin arbiter with combinational grant and priority update on accept.

## Test plan
- **Left load:** after reset, req0 sends dir 0, data 0xA5, len 8.
  - Ready in the same cycle; `sl` high for 8 cycles.
  - din sequence 1,0,1,0,0,1,0,1.
  - `done` at T+9; register Q = 0xA5.
- **Right load:** req1 sends dir 1, data 0x3C, len 0.
  - `sr` high for 8 cycles; din sequence 0,0,1,1,1,1,0,0.
  - Q = 0x3C; `grant_id` = 1.
- **Arbitration:** both valid continuously for two transactions.
  - First grant goes to req0, second to req1.
  - Ready is never high for both at once.
- **Short and clamped lengths:**
  - Left, data 0x05, len 3: 3 `sl` pulses, din 1,0,1, Q[2:0] = 3'b101, `done` at T+4.
  - len 12: clamped to 8 shifts.
- **Reset mid-shift:** reset in the 4th SHIFT cycle.
  - `sl` low next cycle; no `done`; `busy` = 0.
  - A subsequent tie is granted to req0.
- **Hold (SRCTRL_HOLD_EN):** `hold` high for 2 cycles mid-transfer.
  - Strobe low for those 2 cycles; total strobe count still 8.
  - `done` at T+11; Q = data.
